dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready request
// channel and a valid/ready response channel.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present          req_ready  request can be accepted (IDLE only)
//   req_we     1 = store, 0 = load      req_addr   byte address
//   req_wdata  store data               req_be     store byte enables
//   rsp_valid  response present         rsp_ready  initiator takes the response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    misaligned or out-of-range access
//
// State  | meaning
// IDLE   | waiting for a request, req_ready = 1
// WAIT   | request captured, counting down the configured latency
// RESP   | response registered, held until rsp_ready

package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module dmem_responder #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH * 4);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     be_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;

  logic [XLEN-1:0]   mem_q [DEPTH];

  // With zero latency the access happens on the accept edge itself, so the
  // access operands come straight from the request port while in IDLE and
  // from the captured copy otherwise.
  logic              acc_we;
  logic [XLEN-1:0]   acc_addr;
  logic [XLEN-1:0]   acc_wdata;
  logic [NB-1:0]     acc_be;
  logic [AW-1:0]     acc_idx;
  logic              acc_err_d;
  logic [XLEN-1:0]   rsp_rdata_d;
  logic              enter_resp;
  logic              mem_wr;

  always_comb begin
    acc_we      = we_q;
    acc_addr    = addr_q;
    acc_wdata   = wdata_q;
    acc_be      = be_q;
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
    acc_idx     = acc_addr[AW+1:2];
    acc_err_d   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
    rsp_rdata_d = (acc_err_d || acc_we) ? '0 : mem_q[acc_idx];
    enter_resp  = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));
    // Gating on rst keeps a store from landing on an edge where reset is held.
    mem_wr      = enter_resp && acc_we && !acc_err_d && rst;
  end

  // Memory has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= acc_err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= acc_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;

  int tests;
  int fails;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(.XLEN(32), .DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.XLEN(32), .DEPTH(64), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE. Accept happens on the
  // next edge; lat counts edges from the accept edge up to the one that raises
  // rsp_valid (inclusive).
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic rr,
                        output logic [31:0] o_rd, output logic o_er, output int o_lat);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = rr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    o_rd = rsp_rdata; o_er = rsp_err; o_lat = n;
    if (rr) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 1;

    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat);
    chk("st10_lat", 32'(lat), 32'd3);
    chk("st10_err", 32'(er), 32'd0);
    chk("st10_rdata", rd, 32'd0);
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("ld10_lat", 32'(lat), 32'd3);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(er), 32'd0);

    do_req(1'b1, 32'h10, 32'h0000AA00, 4'h2, 1'b1, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("partial_rdata", rd, 32'hDEADAAEF);

    do_req(1'b1, 32'h0, 32'h01234567, 4'hF, 1'b1, rd, er, lat);
    do_req(1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, 1'b1, rd, er, lat);
    chk("st_fc_err", 32'(er), 32'd0);
    do_req(1'b0, 32'hFC, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("ld_fc_rdata", rd, 32'hA5A5A5A5);
    chk("ld_fc_err", 32'(er), 32'd0);

    do_req(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("ld12_err", 32'(er), 32'd1);
    chk("ld12_rdata", rd, 32'd0);
    chk("ld12_lat", 32'(lat), 32'd3);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("ld100_err", 32'(er), 32'd1);
    chk("ld100_rdata", rd, 32'd0);
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat);
    chk("st100_err", 32'(er), 32'd1);
    do_req(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat);
    chk("st11_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("word0_kept", rd, 32'h01234567);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, rd, er, lat);
    chk("word4_kept", rd, 32'hDEADAAEF);

    // Stall in RESP with a stray request pulse.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("stall_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      end
      if (i == 2) req_valid = 1'b0;
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEADAAEF);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("stray_not_taken", rd, 32'hDEADAAEF);

    // Reset during WAIT aborts a pending store.
    do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, lat);
    chk("abort_no_write", rd, 32'h12345678);

    // Reset during RESP clears outputs asynchronously.
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
    chk("resp_valid_pre", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstresp_valid", 32'(rsp_valid), 32'd0);
    chk("rstresp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Zero-latency instance: response one cycle after accept, one every two.
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h4; req_wdata0 = 32'h11112222; req_be0 = 4'hF;
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("l0_st_valid", 32'(rsp_valid0), 32'd1);
    chk("l0_st_err", 32'(rsp_err0), 32'd0);
    req_valid0 = 1'b0;
    @(posedge clk); #1;
    chk("l0_st_done", 32'(rsp_valid0), 32'd0);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h4;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("l0_b2b_valid", 32'(rsp_valid0), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("l0_b2b_rdata", rsp_rdata0, 32'h11112222);
    end
    req_valid0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
